// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: consumer-side PLL controller in the reference-clock domain.
// Pulses the PLL reset and waits for lock, retrying after a timeout. The
// downstream active-low system reset is released only once lock has been
// continuously stable. Lock loss in RUN restarts the whole sequence.
// Optional build macro LOCK_GLITCH_FILTER_EN: in RUN, lock loss is declared only
// after LOSS_FILT_CYC consecutive unlocked samples instead of a single one.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STABLE_CYC       = 4096,
  parameter int MAX_RETRY        = 7,
  parameter int LOSS_FILT_CYC    = 8
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] S_RESET     = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  // One shared cycle counter serves all timed states; size it for the longest.
  localparam int CNT_MAX_A = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYC) ? CNT_MAX_A : STABLE_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  if (RST_PULSE_CYC < 1 || LOCK_TIMEOUT_CYC < 1 || STABLE_CYC < 1 ||
      MAX_RETRY < 1 || MAX_RETRY > 15 || LOSS_FILT_CYC < 1) begin : g_param_check
    $error("pll_lock_supervisor: parameter out of range");
  end

  // Loss events saturate rather than wrap so a flapping PLL stays visible.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             sync_p0;
  logic             lk;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       state_nxt;
  logic [3:0]       retry_nxt;
  logic [3:0]       retry_inc;
  logic [7:0]       loss_nxt;

`ifdef LOCK_GLITCH_FILTER_EN
  localparam int FILT_W = $clog2(LOSS_FILT_CYC + 1);
  logic [FILT_W-1:0] filt;
  logic [FILT_W-1:0] filt_nxt;
`endif

  // Two-flop synchronizer bringing the asynchronous lock flag into refclk.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      lk      <= 1'b0;
    end else begin
      sync_p0 <= pll_locked;
      lk      <= sync_p0;
    end
  end

  // Next-state, counter and event-counter decisions for the sequencing FSM.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    retry_inc = retry_cnt + 4'd1;
    loss_nxt  = loss_cnt;
`ifdef LOCK_GLITCH_FILTER_EN
    filt_nxt  = '0;
`endif
    case (state)
      S_RESET: begin
        if (cnt == CNT_W'(RST_PULSE_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT_LOCK;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        // A lock seen on the timeout cycle wins; the attempt is not counted.
        if (lk) begin
          cnt_nxt   = '0;
          state_nxt = S_STABLE;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
          retry_nxt = retry_inc;
          cnt_nxt   = '0;
          state_nxt = (retry_inc >= 4'(MAX_RETRY)) ? S_FAIL : S_RESET;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_STABLE: begin
        // A dropout here just restarts the wait; it is not a failed attempt.
        if (!lk) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT_LOCK;
        end else if (cnt == CNT_W'(STABLE_CYC - 1)) begin
          cnt_nxt   = '0;
          retry_nxt = 4'd0;
          state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
`ifdef LOCK_GLITCH_FILTER_EN
        // Declare loss the cycle after the filter fills, whatever lk does then.
        if (filt == FILT_W'(LOSS_FILT_CYC)) begin
          loss_nxt  = sat_inc8(loss_cnt);
          cnt_nxt   = '0;
          state_nxt = S_RESET;
        end else if (!lk) begin
          filt_nxt = filt + FILT_W'(1);
        end
`else
        if (!lk) begin
          loss_nxt  = sat_inc8(loss_cnt);
          cnt_nxt   = '0;
          state_nxt = S_RESET;
        end
`endif
      end
      S_FAIL: begin
        if (retry_req) begin
          retry_nxt = 4'd0;
          cnt_nxt   = '0;
          state_nxt = S_RESET;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_RESET;
      end
    endcase
  end

  // State and outputs registered together; outputs decode the next state so
  // sys_rst_n can only rise on entry to RUN.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state     <= S_RESET;
      cnt       <= '0;
      retry_cnt <= 4'd0;
      loss_cnt  <= 8'd0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
      pll_rst   <= (state_nxt == S_RESET) || (state_nxt == S_FAIL);
      sys_rst_n <= (state_nxt == S_RUN);
      ready     <= (state_nxt == S_RUN);
      fail      <= (state_nxt == S_FAIL);
    end
  end

`ifdef LOCK_GLITCH_FILTER_EN
  // Consecutive-unlocked-sample counter; held at zero outside RUN.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      filt <= '0;
    end else begin
      filt <= filt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scenario bench for pll_lock_supervisor. Expected
// values are pushed to a scoreboard queue as stimulus is applied and popped
// when the corresponding DUT response is observed.
module tb_pll_lock_supervisor;

  localparam int RST_PULSE_CYC    = 4;
  localparam int LOCK_TIMEOUT_CYC = 32;
  localparam int STABLE_CYC       = 8;
  localparam int MAX_RETRY        = 3;
  localparam int LOSS_FILT_CYC    = 4;

  // Pin edge -> 2 synchronizer flops -> FSM register, then the stable window.
  localparam int READY_LAT = 2 + 1 + STABLE_CYC;
`ifdef LOCK_GLITCH_FILTER_EN
  localparam int LOSS_LEN = LOSS_FILT_CYC;
  localparam int LOSS_LAT = 2 + 1 + LOSS_FILT_CYC;
`else
  localparam int LOSS_LEN = 1;
  localparam int LOSS_LAT = 2 + 1;
`endif

  localparam int S_RESET = 0, S_WAIT = 1, S_STABLE = 2, S_RUN = 3, S_FAIL = 4;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       retry_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  pll_lock_supervisor #(
    .RST_PULSE_CYC   (RST_PULSE_CYC),
    .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
    .STABLE_CYC      (STABLE_CYC),
    .MAX_RETRY       (MAX_RETRY),
    .LOSS_FILT_CYC   (LOSS_FILT_CYC)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .retry_req (retry_req),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state     (state)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    string name;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_loss = 0;

  task automatic push_exp(input string nm, input int v);
    exp_t t;
    t.name = nm;
    t.val  = v;
    sb_q.push_back(t);
  endtask

  // Packed expected output snapshot: state, pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt.
  function automatic int mk(input int st, input int pr, input int sr, input int rd,
                            input int fl, input int rc, input int lc);
    logic [31:0] v;
    v = {13'd0, 3'(st), 1'(pr), 1'(sr), 1'(rd), 1'(fl), 4'(rc), 8'(lc)};
    return int'(v);
  endfunction

  function automatic int obs();
    logic [31:0] v;
    v = {13'd0, state, pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt};
    return int'(v);
  endfunction

  function automatic logic sig_of(input int which);
    case (which)
      0:       return pll_rst;
      1:       return ready;
      default: return sys_rst_n;
    endcase
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      @(negedge refclk);
    end
  endtask

  // Rising edges until the selected output equals val; -1 if the bound expires.
  task automatic wait_sig(input int which, input logic val, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(posedge refclk);
      @(negedge refclk);
      if (sig_of(which) === val) begin
        n = i;
        break;
      end
    end
  endtask

  // Drop pll_locked for len cycles; report rising edges until sys_rst_n falls (-1 if never).
  task automatic glitch(input int len, input int bound, output int lat);
    lat = -1;
    pll_locked = 1'b0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge refclk);
      @(negedge refclk);
      if (i >= len) pll_locked = 1'b1;
      if (lat < 0 && sys_rst_n === 1'b0) lat = i;
      if (lat >= 0 && i >= len) break;
    end
    pll_locked = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    retry_req = 1'b0;
    push_exp("reset_state", mk(S_RESET, 1, 0, 0, 0, 0, 0));
    tick(3);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
  endtask

  task automatic test_clean_lock();
    exp_t e;
    int n;
    push_exp("clean_rst_pulse", RST_PULSE_CYC);
    rst_n = 1'b1;
    wait_sig(0, 1'b0, 50, n);
    e = sb_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, n, e.val); end
    tick(10 - RST_PULSE_CYC);
    push_exp("clean_ready_lat", READY_LAT);
    pll_locked = 1'b1;
    wait_sig(1, 1'b1, 200, n);
    e = sb_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, n, e.val); end
    push_exp("clean_run_state", mk(S_RUN, 0, 1, 1, 0, 0, 0));
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
  endtask

  task automatic test_timeout();
    exp_t e;
    int n;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int k = 1; k <= MAX_RETRY; k++) begin
      push_exp("timeout_pulse_len", RST_PULSE_CYC);
      wait_sig(0, 1'b0, 50, n);
      e = sb_q.pop_front(); checks++;
      if (n !== e.val) begin errors++; $display("FAIL %s[%0d]: got %0d want %0d", e.name, k, n, e.val); end
      push_exp("timeout_wait_len", LOCK_TIMEOUT_CYC);
      wait_sig(0, 1'b1, 100, n);
      e = sb_q.pop_front(); checks++;
      if (n !== e.val) begin errors++; $display("FAIL %s[%0d]: got %0d want %0d", e.name, k, n, e.val); end
      if (k < MAX_RETRY) push_exp("timeout_retry_state", mk(S_RESET, 1, 0, 0, 0, k, 0));
      else               push_exp("timeout_fail_state", mk(S_FAIL, 1, 0, 0, 1, k, 0));
      e = sb_q.pop_front(); checks++;
      if (obs() !== e.val) begin errors++; $display("FAIL %s[%0d]: got %05h want %05h", e.name, k, obs(), e.val); end
    end
    push_exp("fail_hold", mk(S_FAIL, 1, 0, 0, 1, MAX_RETRY, 0));
    tick(5);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
    push_exp("retry_req_exit", mk(S_RESET, 1, 0, 0, 0, 0, 0));
    retry_req = 1'b1;
    tick(1);
    retry_req = 1'b0;
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
    push_exp("retry_pulse_len", RST_PULSE_CYC);
    wait_sig(0, 1'b0, 50, n);
    e = sb_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, n, e.val); end
    push_exp("retry_req_ignored", mk(S_WAIT, 0, 0, 0, 0, 0, 0));
    retry_req = 1'b1;
    tick(1);
    retry_req = 1'b0;
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
  endtask

  task automatic test_unstable_lock();
    exp_t e;
    int n;
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    push_exp("unstable_in_stable", mk(S_STABLE, 0, 0, 0, 0, 0, 0));
    tick(1);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
    push_exp("unstable_abort", mk(S_WAIT, 0, 0, 0, 0, 0, 0));
    tick(1);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
    push_exp("unstable_ready_lat", READY_LAT - 2);
    wait_sig(1, 1'b1, 200, n);
    e = sb_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, n, e.val); end
  endtask

  task automatic test_loss_in_run();
    exp_t e;
    int n;
    int lat;
`ifdef LOCK_GLITCH_FILTER_EN
    push_exp("filt_short_glitch", -1);
    glitch(LOSS_FILT_CYC - 1, 20, lat);
    e = sb_q.pop_front(); checks++;
    if (lat !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, lat, e.val); end
    push_exp("filt_short_state", mk(S_RUN, 0, 1, 1, 0, 0, 0));
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
`endif
    push_exp("loss_lat", LOSS_LAT);
    glitch(LOSS_LEN, 40, lat);
    exp_loss = 1;
    e = sb_q.pop_front(); checks++;
    if (lat !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, lat, e.val); end
    push_exp("loss_state", mk(S_RESET, 1, 0, 0, 0, 0, exp_loss));
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
    push_exp("loss_rst_pulse", RST_PULSE_CYC);
    wait_sig(0, 1'b0, 50, n);
    e = sb_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, n, e.val); end
    push_exp("relock_lat", STABLE_CYC + 1);
    wait_sig(1, 1'b1, 200, n);
    e = sb_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, n, e.val); end
  endtask

  task automatic test_saturate_and_midreset();
    exp_t e;
    int n;
    int lat;
    for (int k = 0; k < 257; k++) begin
      glitch(LOSS_LEN, 40, lat);
      wait_sig(1, 1'b1, 200, n);
      exp_loss = (exp_loss >= 255) ? 255 : exp_loss + 1;
      checks++;
      if (lat < 0 || n < 0) begin
        errors++;
        $display("FAIL loss_loop[%0d]: got lat %0d relock %0d want both >= 0", k, lat, n);
        break;
      end
    end
    push_exp("loss_saturate", mk(S_RUN, 0, 1, 1, 0, 0, exp_loss));
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
    push_exp("midreset_run", mk(S_RESET, 1, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    tick(1);
    exp_loss = 0;
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
    push_exp("midreset_run_pulse", RST_PULSE_CYC);
    rst_n = 1'b1;
    wait_sig(0, 1'b0, 50, n);
    e = sb_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, n, e.val); end
    push_exp("midreset_enter_stable", mk(S_STABLE, 0, 0, 0, 0, 0, 0));
    tick(2);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
    push_exp("midreset_stable", mk(S_RESET, 1, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    tick(1);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
    push_exp("midreset_stable_pulse", RST_PULSE_CYC);
    rst_n = 1'b1;
    wait_sig(0, 1'b0, 50, n);
    e = sb_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, n, e.val); end
  endtask

  task automatic test_timeout_priority_and_clear();
    exp_t e;
    int n;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    tick(1);
    rst_n = 1'b1;
    wait_sig(0, 1'b0, 50, n);
    wait_sig(0, 1'b1, 100, n);
    push_exp("one_retry_state", mk(S_RESET, 1, 0, 0, 0, 1, 0));
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
    wait_sig(0, 1'b0, 50, n);
    // Time the pin so the FSM first sees lk=1 on the timeout cycle itself.
    tick(LOCK_TIMEOUT_CYC - 3);
    pll_locked = 1'b1;
    push_exp("lock_on_timeout_cycle", mk(S_STABLE, 0, 0, 0, 0, 1, 0));
    tick(3);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
    push_exp("run_clears_retry", mk(S_RUN, 0, 1, 1, 0, 0, 0));
    wait_sig(1, 1'b1, 200, n);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.val) begin errors++; $display("FAIL %s: got %05h want %05h", e.name, obs(), e.val); end
  endtask

  initial begin
    rst_n = 1'b0;
    pll_locked = 1'b0;
    retry_req = 1'b0;
    @(negedge refclk);
    test_reset();
    test_clean_lock();
    test_timeout();
    test_unstable_lock();
    test_loss_in_run();
    test_saturate_and_midreset();
    test_timeout_priority_and_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
